rv32im_div_unit: RTL and testbench

- Iterative radix-2 divider for the RV32IM M-extension ops DIV, DIVU, REM and REMU.
- Sits in the execute stage beside rv32im_alu and takes the same operand buses from the issue logic.
- Its result feeds the execute result mux in place of alu_o whenever a divide op is selected.
- Multi-cycle, with valid/ready handshakes on both the input and output sides.

---
 rtl/rv32im_div_unit.sv | 112 +++++++++++
 tb/tb_rv32im_div_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/rv32im_div_unit.sv
// rv32im_div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional RV32IM_DIV_FAST_PATH_EN returns at once when |divisor| > |dividend|.
module rv32im_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            div_valid_i,
  output logic            div_ready_o,
  input  logic [1:0]      div_op_i,
  input  logic [XLEN-1:0] div_operand_1_i,
  input  logic [XLEN-1:0] div_operand_2_i,
  input  logic            div_kill_i,
  output logic            div_result_valid_o,
  input  logic            div_result_ready_i,
  output logic [XLEN-1:0] div_result_o,
  output logic            div_busy_o
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t            state_q, state_d;
  logic              rem_sel_q, rem_sel_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sgn, a_neg, b_neg, div0, ovf, fast, accept, ge;
  logic [XLEN-1:0]   abs_a, abs_b, new_rem, new_quo;
  logic [XLEN:0]     shifted;
  assign div_ready_o        = state_q == IDLE;
  assign div_result_valid_o = state_q == DONE;
  assign div_busy_o         = state_q != IDLE;
  assign div_result_o       = result_q;
  always_comb begin
    sgn     = ~div_op_i[0];
    a_neg   = sgn & div_operand_1_i[XLEN-1];
    b_neg   = sgn & div_operand_2_i[XLEN-1];
    abs_a   = a_neg ? -div_operand_1_i : div_operand_1_i;
    abs_b   = b_neg ? -div_operand_2_i : div_operand_2_i;
    div0    = div_operand_2_i == '0;
    ovf     = sgn & (div_operand_1_i == MIN) & (&div_operand_2_i);
`ifdef RV32IM_DIV_FAST_PATH_EN
    fast    = !div0 && (abs_b > abs_a);
`else
    fast    = 1'b0;
`endif
    accept  = div_valid_i & div_ready_o & ~div_kill_i;
    // rem < divisor always holds, so the shifted value is below 2*divisor and the difference fits XLEN bits
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = shifted >= {1'b0, dvs_q};
    new_rem = ge ? shifted[XLEN-1:0] - dvs_q : shifted[XLEN-1:0];
    new_quo = {quo_q[XLEN-2:0], ge};
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: if (accept) begin
        rem_sel_d = div_op_i[1];
        qneg_d    = (div_op_i == 2'b00) & (a_neg ^ b_neg);
        rneg_d    = (div_op_i == 2'b10) & a_neg;
        dvs_d     = abs_b;
        rem_d     = '0;
        quo_d     = abs_a;
        cnt_d     = CNT_W'(XLEN-1);
        state_d   = (div0 | ovf | fast) ? DONE : CALC;
        result_d  = div0 ? (div_op_i[1] ? div_operand_1_i : '1) :
                    ovf  ? (div_op_i[1] ? '0 : MIN) :
                           (div_op_i[1] ? div_operand_1_i : '0);
      end
      CALC: begin
        rem_d = new_rem;
        quo_d = new_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = rem_sel_q ? (rneg_q ? -new_rem : new_rem) : (qneg_q ? -new_quo : new_quo);
        end
      end
      DONE: state_d = div_result_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (div_kill_i && state_q != IDLE) state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end
endmodule

// File: tb/tb_rv32im_div_unit.sv
// tb_rv32im_div_unit: directed checks of rv32im_div_unit results, latency, kill, backpressure and reset.
module tb_rv32im_div_unit;
  logic        clk = 0, rst = 1, valid = 0, kill = 0, res_ready = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic        ready, res_valid, busy;
  logic [31:0] result, held;
  int          checks = 0, fails = 0;
  rv32im_div_unit dut (
    .clk_i(clk), .rst_i(rst), .div_valid_i(valid), .div_ready_o(ready), .div_op_i(op),
    .div_operand_1_i(a), .div_operand_2_i(b), .div_kill_i(kill),
    .div_result_valid_o(res_valid), .div_result_ready_i(res_ready),
    .div_result_o(result), .div_busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    valid = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    valid = 0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int lat);
    int n;
    start(o, x, y);
    n = 1;
    check({tag, " ready_low"}, 32'(ready), 32'd0);
    while (!res_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, result, exp);
    @(negedge clk); res_ready = 1;
    @(posedge clk); #1; res_ready = 0;
    check({tag, " ready_after"}, 32'(ready), 32'd1);
  endtask
  initial begin
    #12;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_valid", 32'(res_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 0;
    run("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h0000000E, 33);
    run("remu_100_7", 2'b11, 32'd100, 32'd7, 32'h00000002, 33);
    run("div_m7_2", 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("rem_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("div_7_m2", 2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run("divu_by0", 2'b01, 32'h00438978, 32'd0, 32'hFFFFFFFF, 1);
    run("rem_by0", 2'b10, 32'h00438978, 32'd0, 32'h00438978, 1);
    run("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run("divu_big", 2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    // kill after ten iterations
    start(2'b01, 32'h00083728, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    check("kill_busy_calc", 32'(busy), 32'd1);
    @(negedge clk); kill = 1;
    @(posedge clk); #1; kill = 0;
    check("kill_ready", 32'(ready), 32'd1);
    check("kill_valid", 32'(res_valid), 32'd0);
    check("kill_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("kill_no_late_valid", 32'(res_valid), 32'd0);
    run("divu_after_kill", 2'b01, 32'h00438978, 32'd5, 32'h000D81E4, 33);
    // kill in idle drops the request
    @(negedge clk); valid = 1; kill = 1; op = 2'b01; a = 32'd9; b = 32'd3;
    @(posedge clk); #1; valid = 0; kill = 0;
    check("idle_kill_busy", 32'(busy), 32'd0);
    check("idle_kill_ready", 32'(ready), 32'd1);
    // backpressure: result held, new requests ignored
    start(2'b01, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    #1;
    check("bp_valid", 32'(res_valid), 32'd1);
    held = result;
    @(negedge clk); valid = 1; op = 2'b01; a = 32'd50; b = 32'd5;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_stable", result, 32'h0000000E);
      check("bp_hold_valid", 32'(res_valid), 32'd1);
      check("bp_ready_low", 32'(ready), 32'd0);
    end
    valid = 0;
    check("bp_held_value", held, 32'h0000000E);
    @(negedge clk); res_ready = 1;
    @(posedge clk); #1; res_ready = 0;
    check("bp_release_ready", 32'(ready), 32'd1);
    check("bp_release_valid", 32'(res_valid), 32'd0);
    // asynchronous reset in the middle of CALC
    start(2'b00, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 0;
    run("divu_after_rst", 2'b01, 32'd50, 32'd5, 32'h0000000A, 33);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
